// File: rtl/ifu_brchmis_rcv.sv
// ---------------------------------------------------------------------------
// ifu_brchmis_rcv
//
// IFU side of the EXU branch-mispredict flush interface. The block owns the
// fetch PC and issues sequential fetch requests, with at most one
// outstanding. Each fetched instruction goes into a single output register
// for decode. A flush redirects the PC to op1 + op2. Any fetch response still
// in flight when the flush arrives is consumed and thrown away.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   brchmis_flush_req/ack      flush handshake (ack = req, always ready)
//   brchmis_flush_add_op1/op2  redirect target adder operands
//   ifu_req_valid/ready/pc     fetch request channel
//   ifu_rsp_valid/ready/instr  fetch response channel
//   ifu_o_valid/ready/pc/ir    instruction output to decode
//   ifu_brchmis_cnt            saturating flush counter (BRCHMIS_CNT_EN only)
//
// Optional build macro: BRCHMIS_CNT_EN adds the flush counter and its port.
// ---------------------------------------------------------------------------
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

module ifu_brchmis_rcv #(
    parameter logic [`PC_SIZE-1:0] RESET_PC = 32'h8000_0000,
    parameter int                  INSTR_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                brchmis_flush_req,
    output logic                brchmis_flush_ack,
    input  logic [`PC_SIZE-1:0] brchmis_flush_add_op1,
    input  logic [`PC_SIZE-1:0] brchmis_flush_add_op2,
    output logic                ifu_req_valid,
    input  logic                ifu_req_ready,
    output logic [`PC_SIZE-1:0] ifu_req_pc,
    input  logic                ifu_rsp_valid,
    output logic                ifu_rsp_ready,
    input  logic [INSTR_W-1:0]  ifu_rsp_instr,
    output logic                ifu_o_valid,
    input  logic                ifu_o_ready,
    output logic [`PC_SIZE-1:0] ifu_o_pc,
    output logic [INSTR_W-1:0]  ifu_o_ir
`ifdef BRCHMIS_CNT_EN
    ,
    output logic [31:0]         ifu_brchmis_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_RSP     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [`PC_SIZE-1:0] pc_r;
    logic [`PC_SIZE-1:0] flush_target;
    logic                flush;
    logic                rsp_take;   // response captured into the output register

    // The IFU is always able to accept a flush.
    assign flush             = brchmis_flush_req;
    assign brchmis_flush_ack = brchmis_flush_req;

    // Carry out of the adder is dropped; there is no alignment check.
    assign flush_target = brchmis_flush_add_op1 + brchmis_flush_add_op2;
    assign ifu_req_pc   = pc_r;

    always_comb begin
        state_nxt     = state;
        ifu_req_valid = 1'b0;
        ifu_rsp_ready = 1'b0;
        rsp_take      = 1'b0;
        case (state)
            S_REQ: begin
                // A flush suppresses the request so that the stale PC is never issued.
                ifu_req_valid = ~flush;
                if (!flush && ifu_req_ready)
                    state_nxt = S_RSP;
            end
            S_RSP: begin
                // One-entry output register with no bypass: take the response
                // only when the slot is free or is being drained this cycle.
                ifu_rsp_ready = ~ifu_o_valid | ifu_o_ready;
                if (ifu_rsp_valid && ifu_rsp_ready) begin
                    state_nxt = S_REQ;
                    rsp_take  = ~flush;
                end else if (flush) begin
                    state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                // Consume the stale response. A further flush here only
                // moves the target. If the stale response completes in the
                // same cycle, nothing is left outstanding, so fetching resumes.
                ifu_rsp_ready = 1'b1;
                if (ifu_rsp_valid)
                    state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_REQ;
        else
            state <= state_nxt;
    end

    // A flush takes priority over the sequential PC advance and the output load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r        <= RESET_PC;
            ifu_o_valid <= 1'b0;
            ifu_o_pc    <= '0;
            ifu_o_ir    <= '0;
        end else if (flush) begin
            pc_r        <= flush_target;
            ifu_o_valid <= 1'b0;
        end else if (rsp_take) begin
            pc_r        <= pc_r + `PC_SIZE'(4);
            ifu_o_valid <= 1'b1;
            ifu_o_pc    <= pc_r;
            ifu_o_ir    <= ifu_rsp_instr;
        end else if (ifu_o_ready) begin
            ifu_o_valid <= 1'b0;
        end
    end

`ifdef BRCHMIS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ifu_brchmis_cnt <= '0;
        else if (brchmis_flush_req && brchmis_flush_ack && ifu_brchmis_cnt != 32'hFFFF_FFFF)
            ifu_brchmis_cnt <= ifu_brchmis_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/ifu_brchmis_rcv.md
Name: ifu_brchmis_rcv

Overview:
IFU-side receiver of the EXU branch-mispredict flush interface, and owner of the fetch PC.
- Accepts a flush request and computes the redirect target as op1 + op2.
- Generates sequential fetch requests: one outstanding at most.
- Holds the fetched instruction in a single output register for the decode stage.
- Discards any in-flight fetch response made stale by a flush.

Parameters:
RESET_PC, 32'h8000_0000, fetch address after reset; width `PC_SIZE.
INSTR_W, 32, instruction width.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
brchmis_flush_req  in  1  flush request from EXU branch resolve
brchmis_flush_ack  out  1  flush accepted
brchmis_flush_add_op1  in  `PC_SIZE  target adder operand 1
brchmis_flush_add_op2  in  `PC_SIZE  target adder operand 2
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  memory accepts request
ifu_req_pc  out  `PC_SIZE  fetch address
ifu_rsp_valid  in  1  fetch response valid
ifu_rsp_ready  out  1  IFU accepts response
ifu_rsp_instr  in  INSTR_W  fetched instruction
ifu_o_valid  out  1  instruction to decode valid
ifu_o_ready  in  1  decode accepts
ifu_o_pc  out  `PC_SIZE  PC of ifu_o_ir
ifu_o_ir  out  INSTR_W  instruction
ifu_brchmis_cnt  out  32  flush count (only when BRCHMIS_CNT_EN defined)

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values:
  - state = S_REQ; pc_r = RESET_PC.
  - ifu_o_valid = 0; ifu_o_pc = 0; ifu_o_ir = 0.
  - ifu_brchmis_cnt = 0.
- Flush acceptance: the IFU is always ready, so brchmis_flush_ack = brchmis_flush_req combinationally. Every request is accepted in the cycle it is asserted.
- Flush target: target = op1 + op2, truncated to `PC_SIZE; carry is dropped. There is no alignment check.
- ifu_req_pc = pc_r.
- States:
  - S_REQ: ifu_req_valid = 1 unless a flush is present this cycle. ifu_rsp_ready = 0.
    - Request handshake (valid & ready) -> S_RSP.
  - S_RSP: ifu_req_valid = 0. ifu_rsp_ready = ~ifu_o_valid | ifu_o_ready.
    - Response handshake: ifu_o_ir <= instr; ifu_o_pc <= pc_r; ifu_o_valid <= 1; pc_r <= pc_r + 4; -> S_REQ.
  - S_DISCARD: ifu_req_valid = 0. ifu_rsp_ready = 1.
    - Response handshake: data dropped; -> S_REQ.
- Output register:
  - ifu_o_valid is cleared on ifu_o_ready & ifu_o_valid, unless it is reloaded in the same cycle.
  - It holds while ifu_o_ready = 0. The register is one entry, with no bypass from response to output.
- Flush accepted (priority over all other updates):
  - pc_r <= target; ifu_o_valid <= 0.
  - S_REQ: request is suppressed this cycle (no handshake) -> S_REQ.
  - S_RSP with response handshake this cycle: response dropped -> S_REQ.
  - S_RSP without response: -> S_DISCARD.
  - S_DISCARD: stay, with pc_r updated. A later flush overrides an earlier target.
- pc_r increments by 4 and wraps modulo 2^`PC_SIZE.
- Latency:
  - Flush at cycle N, no request outstanding -> ifu_req_valid with ifu_req_pc = target at cycle N+1.
  - Fetch throughput is at most one instruction per 2 cycles.
- Asynchronous reset mid-operation: immediately returns to the reset values. Any outstanding response after reset is not tracked; the memory side is reset by the same rst_n.

Optional Feature:
BRCHMIS_CNT_EN
- Defined: port ifu_brchmis_cnt exists. It increments by 1 on each accepted flush (flush_req & flush_ack), saturates at 32'hFFFF_FFFF, and resets to 0.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Reset release, memory always ready, rsp one cycle after request:
  - ifu_req_pc sequence 8000_0000, 8000_0004, 8000_0008.
  - ifu_o_pc matches each request with its instr.
- Flush op1 = 8000_0010, op2 = 0000_0100 in S_REQ:
  - flush_ack = 1 in the same cycle; no handshake that cycle.
  - Next cycle ifu_req_pc = 8000_0110; ifu_o_valid = 0.
- Flush while a request is outstanding (S_RSP), op1 = 8000_0000, op2 = FFFF_FFFC:
  - Response arriving 3 cycles later is consumed (rsp_ready = 1) and never appears on ifu_o.
  - Then ifu_req_pc = 7FFF_FFFC.
- Flush in the same cycle as the response handshake: response dropped; next request is at the target.
- Decode stall (ifu_o_ready = 0 for 5 cycles):
  - ifu_o_ir/ifu_o_pc are held; ifu_rsp_ready = 0.
  - No PC advance beyond the single outstanding fetch.
- With BRCHMIS_CNT_EN: 3 flushes, including 2 in consecutive cycles while in S_DISCARD -> ifu_brchmis_cnt = 3; last target wins.
